// File: rtl/serial_ripple_subtractor_if.sv
// Launch/collect handshake and operand/result bus of the bit-serial subtractor.
// The controller drives the master side; the subtractor implements the slave side.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a_in, b_in, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a_in, b_in, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - borrow_in, one bit per clock, LSB first,
// with a registered borrow chain and a start/busy/done handshake.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  serial_ripple_subtractor_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] diff_r;
  logic             bw;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       slice;

  // One full-subtractor bit slice; returns {borrow_next, diff_bit}.
  function automatic logic [1:0] sub_slice(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

  assign slice = sub_slice(a_sr[0], b_sr[0], bw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      diff_r   <= '0;
      bw       <= 1'b0;
      borrow_r <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= BUSY;
            a_sr  <= bus.a_in;
            b_sr  <= bus.b_in;
            bw    <= bus.borrow_in;
            cnt   <= '0;
          end
        end
        BUSY: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {slice[0], res_sr[WIDTH-1:1]};
          bw     <= slice[1];
          cnt    <= cnt + 1'b1;
          // Result is published only once all slices are in, so partial bits never show.
          if (cnt == LAST_CNT) begin
            state    <= DONE;
            diff_r   <= {slice[0], res_sr[WIDTH-1:1]};
            borrow_r <= slice[1];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_r;
endmodule
